// File: rtl/fphub_pkg.sv
// Shared defaults, special-value constants and the class tag carried between
// the two converter stages.
package fphub_pkg;

   localparam int M_DEF = 24;
   localparam int E_DEF = 8;
   localparam int BIAS  = 2**(E_DEF-1) - 1;

   localparam logic [E_DEF-1:0] EXP_MAX   = '1;
   localparam logic [M_DEF-2:0] QNAN_FRAC = {1'b1, {(M_DEF-2){1'b0}}};

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_FINITE,
      CLS_INF,
      CLS_NAN
   } class_t;

endpackage

// File: rtl/fphub_pipe_reg.sv
// Generic valid/ready register slice: one entry with full backpressure.
// Its data is held while the slice is full and the consumer stalls.
module fphub_pipe_reg #(
   parameter int P = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [P-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [P-1:0] out_data
);

   logic         valid_reg;
   logic [P-1:0] data_reg;

   assign in_ready  = !valid_reg || out_ready;
   assign out_valid = valid_reg;
   assign out_data  = data_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (in_ready) begin
         valid_reg <= in_valid;
         if (in_valid) begin
            data_reg <= in_data;
         end
      end
   end

endmodule

// File: rtl/fphub_to_ieee_converter.sv
// FPHUB to IEEE-754 output converter: stage 1 classifies and rounds to nearest
// even, stage 2 packs the IEEE word and produces per-word and sticky flags.
module fphub_to_ieee_converter
   import fphub_pkg::*;
#(
   parameter  int M = M_DEF,
   parameter  int E = E_DEF,
   localparam int W = E + M
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_hub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_ieee,
   output logic         out_inexact,
   output logic         out_overflow,
   input  logic         flag_clear,
   output logic         sticky_inexact,
   output logic         sticky_overflow
);

   localparam logic [E-1:0] EXP_ONES = '1;
   localparam logic [M-2:0] QNAN_F   = {1'b1, {(M-2){1'b0}}};

   // ---------------- stage 1: classify and round ----------------
   logic           sign_in;
   logic [E-1:0]   exp_in;
   logic [M-2:0]   frac_in;
   logic [E+M-2:0] mag_rnd;
   class_t         cls_in;
   logic [W+1:0]   s1_in_data;
   logic [W+1:0]   s1_data;
   logic           s1_valid;
   logic           s1_in_ready;
   logic           s2_can_load;

   assign sign_in = in_hub[W-1];
   assign exp_in  = in_hub[W-2 -: E];
   assign frac_in = in_hub[M-2:0];

   // The implicit half-LSB makes every finite word an exact tie, so the
   // even neighbour is reached by adding the stored LSB; a fraction carry
   // ripples naturally into the exponent field.
   assign mag_rnd = in_hub[W-2:0] + {{(E+M-2){1'b0}}, frac_in[0]};

   always_comb begin
      cls_in = CLS_FINITE;
      if (exp_in == '0) begin
         cls_in = CLS_ZERO;
      end else if (exp_in == EXP_ONES) begin
         cls_in = (frac_in == '0) ? CLS_INF : CLS_NAN;
      end
   end

   assign s1_in_data = {sign_in, cls_in, mag_rnd};

   fphub_pipe_reg #(.P(W+2)) u_stage1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (s1_in_ready),
      .in_data   (s1_in_data),
      .out_valid (s1_valid),
      .out_ready (s2_can_load),
      .out_data  (s1_data)
   );

   assign in_ready = rst_n && s1_in_ready;

   // ---------------- stage 2: pack and flag ----------------
   logic           sign1;
   class_t         cls1;
   logic [E+M-2:0] mag1;
   logic [E-1:0]   exp1;
   logic [W-1:0]   word2;
   logic           inexact2;
   logic           overflow2;
   logic [W+1:0]   s2_data;

   assign sign1 = s1_data[W+1];
   assign cls1  = class_t'(s1_data[W:W-1]);
   assign mag1  = s1_data[W-2:0];
   assign exp1  = mag1[E+M-2 -: E];

   always_comb begin
      word2     = {sign1, {(W-1){1'b0}}};
      inexact2  = 1'b0;
      overflow2 = 1'b0;
      case (cls1)
         CLS_ZERO:   word2 = {sign1, {(W-1){1'b0}}};
         CLS_INF:    word2 = {sign1, EXP_ONES, {(M-1){1'b0}}};
         CLS_NAN:    word2 = {sign1, EXP_ONES, QNAN_F};
         CLS_FINITE: begin
            inexact2 = 1'b1;
            if (exp1 == EXP_ONES) begin
               word2     = {sign1, EXP_ONES, {(M-1){1'b0}}};
               overflow2 = 1'b1;
            end else begin
               word2 = {sign1, mag1};
            end
         end
         default:    word2 = {sign1, {(W-1){1'b0}}};
      endcase
   end

   fphub_pipe_reg #(.P(W+2)) u_stage2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s2_can_load),
      .in_data   ({word2, inexact2, overflow2}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_data)
   );

   assign out_ieee     = s2_data[W+1:2];
   assign out_inexact  = s2_data[1];
   assign out_overflow = s2_data[0];

   // Clear takes priority over a coinciding handoff.
   always_ff @(posedge clk) begin
      if (!rst_n || flag_clear) begin
         sticky_inexact  <= 1'b0;
         sticky_overflow <= 1'b0;
      end else if (out_valid && out_ready) begin
         sticky_inexact  <= sticky_inexact  | out_inexact;
         sticky_overflow <= sticky_overflow | out_overflow;
      end
   end

endmodule

// File: tb/tb_fphub_to_ieee_converter.sv
// Directed bench for the FPHUB to IEEE converter: a value-level rounding model
// feeds a scoreboard checked on every output handoff, plus literal vectors.
module tb_fphub_to_ieee_converter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_hub = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_ieee;
   logic        out_inexact;
   logic        out_overflow;
   logic        flag_clear = 1'b0;
   logic        sticky_inexact;
   logic        sticky_overflow;

   int checks = 0;
   int failures = 0;
   int n_out = 0;

   fphub_to_ieee_converter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_hub          (in_hub),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_ieee        (out_ieee),
      .out_inexact     (out_inexact),
      .out_overflow    (out_overflow),
      .flag_clear      (flag_clear),
      .sticky_inexact  (sticky_inexact),
      .sticky_overflow (sticky_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Value model: the exact value is (1.frac + half ulp) * 2^(exp-bias); of
   // the two neighbours frac and frac+1 pick the even one, renormalising on carry.
   function automatic logic [33:0] model(input logic [31:0] h);
      logic        s;
      int          e;
      int unsigned q;
      logic [31:0] qv;
      logic [31:0] ev;
      s = h[31];
      e = int'(h[30:23]);
      q = int'(h[22:0]);
      if (e == 0) return {s, 31'h0, 2'b00};
      if (e == 255) begin
         if (q == 0) return {s, 8'hFF, 23'h0, 2'b00};
         return {s, 8'hFF, 1'b1, 22'h0, 2'b00};
      end
      if (q % 2 == 1) q = q + 1;
      if (q == (1 << 23)) begin
         q = 0;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0, 2'b11};
      qv = q;
      ev = e;
      return {s, ev[7:0], qv[22:0], 2'b10};
   endfunction

   // Scoreboard / sticky / stall monitor, sampled on the falling edge.
   logic [33:0] sb[$];
   logic        m_si = 1'b0, m_so = 1'b0, started = 1'b0;
   logic        prev_stall = 1'b0;
   logic [33:0] prev_out;

   always @(negedge clk) begin
      logic [33:0] e;
      logic        handoff;
      e = '0;
      handoff = 1'b0;
      if (!rst_n) begin
         chk("in_ready_in_reset", {63'h0, in_ready}, 64'h0);
         sb.delete();
         prev_stall = 1'b0;
         started = 1'b1;
         m_si = 1'b0;
         m_so = 1'b0;
      end else begin
         if (started) begin
            chk("sticky_flags", {62'h0, sticky_inexact, sticky_overflow}, {62'h0, m_si, m_so});
         end
         if (prev_stall) begin
            chk("stall_stable", {out_valid, out_ieee, out_inexact, out_overflow}, {1'b1, prev_out});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", {32'h0, out_ieee}, 64'hDEAD);
            end else begin
               e = sb.pop_front();
               handoff = 1'b1;
               chk("out_word", {30'h0, out_ieee, out_inexact, out_overflow}, {30'h0, e});
               n_out++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out = {out_ieee, out_inexact, out_overflow};
         if (in_valid && in_ready) sb.push_back(model(in_hub));
         if (flag_clear) begin
            m_si = 1'b0;
            m_so = 1'b0;
         end else if (handoff) begin
            m_si = m_si | e[1];
            m_so = m_so | e[0];
         end
      end
   end

   task automatic send_one(input string name, input logic [31:0] hub, input logic [31:0] req_word,
                           input logic req_inex, input logic req_ovf);
      logic got;
      int   tries;
      int   lat;
      in_valid = 1'b1;
      in_hub = hub;
      tries = 0;
      do begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         tries++;
      end while (!got && tries < 20);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'd2);
      chk({name, "_word"}, {30'h0, out_ieee, out_inexact, out_overflow},
          {30'h0, req_word, req_inex, req_ovf});
      $display("xfer %s in=%h out=%h inexact=%0b overflow=%0b", name, hub, out_ieee, out_inexact, out_overflow);
   endtask

   logic [31:0] stream_vec [8] = '{32'h40400000, 32'h40400001, 32'h3FFFFFFF, 32'h80000000,
                                   32'hFF800000, 32'h7F800005, 32'hBF800003, 32'h00000123};

   initial begin
      logic saw_low;
      int   base;
      int   wait_cyc;
      saw_low = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {28'h0, out_valid, out_ieee, out_inexact, out_overflow, sticky_inexact, sticky_overflow},
          64'h0);
      rst_n = 1'b1;
      out_ready = 1'b1;

      chk("model_3p0",   64'(model(32'h40400000)), {30'h0, 32'h40400000, 2'b10});
      chk("model_odd",   64'(model(32'h40400001)), {30'h0, 32'h40400002, 2'b10});
      chk("model_carry", 64'(model(32'h3FFFFFFF)), {30'h0, 32'h40000000, 2'b10});
      chk("model_ovf",   64'(model(32'h7F7FFFFF)), {30'h0, 32'h7F800000, 2'b11});
      chk("model_nan",   64'(model(32'h7F800005)), {30'h0, 32'h7FC00000, 2'b00});

      send_one("three",   32'h40400000, 32'h40400000, 1'b1, 1'b0);
      send_one("odd_lsb", 32'h40400001, 32'h40400002, 1'b1, 1'b0);
      send_one("carry",   32'h3FFFFFFF, 32'h40000000, 1'b1, 1'b0);
      send_one("max_even", 32'h7F7FFFFE, 32'h7F7FFFFE, 1'b1, 1'b0);
      send_one("overflow", 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      chk("sticky_ovf_set", {63'h0, sticky_overflow}, 64'h1);
      repeat (2) @(posedge clk);
      #1;
      chk("sticky_ovf_hold", {63'h0, sticky_overflow}, 64'h1);
      flag_clear = 1'b1;
      @(posedge clk);
      #1;
      flag_clear = 1'b0;
      chk("sticky_cleared", {62'h0, sticky_inexact, sticky_overflow}, 64'h0);

      send_one("neg_zero", 32'h80000000, 32'h80000000, 1'b0, 1'b0);
      send_one("zero_frac", 32'h00000123, 32'h00000000, 1'b0, 1'b0);
      send_one("neg_inf",  32'hFF800000, 32'hFF800000, 1'b0, 1'b0);
      send_one("nan",      32'h7F800005, 32'h7FC00000, 1'b0, 1'b0);
      chk("sticky_after_specials", {62'h0, sticky_inexact, sticky_overflow}, 64'h0);

      // Clear coinciding with a handoff: the handoff's flags are dropped.
      send_one("clr_race", 32'h40400001, 32'h40400002, 1'b1, 1'b0);
      flag_clear = 1'b1;
      @(posedge clk);
      #1;
      flag_clear = 1'b0;
      chk("clear_wins", {63'h0, sticky_inexact}, 64'h0);

      base = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic got;
               int   tries;
               in_valid = 1'b1;
               in_hub = stream_vec[i];
               tries = 0;
               do begin
                  @(negedge clk);
                  got = in_ready;
                  if (!got) saw_low = 1'b1;
                  @(posedge clk);
                  #1;
                  tries++;
               end while (!got && tries < 20);
               $display("xfer stream_in idx=%0d in=%h", i, stream_vec[i]);
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 40; c++) begin
               out_ready = (c % 4 == 0) || (c % 4 == 3);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_cyc = 0;
      while (n_out < base + 8 && wait_cyc < 50) begin
         @(posedge clk);
         #1;
         wait_cyc++;
      end
      chk("stream_count", 64'(n_out - base), 64'd8);
      chk("stream_backpressure", {63'h0, saw_low}, 64'h1);
      chk("stream_sb_empty", 64'(sb.size()), 64'd0);
      chk("sticky_after_stream", {62'h0, sticky_inexact, sticky_overflow}, 64'h2);

      // Two words in flight, then a one-cycle reset.
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_hub = 32'h3FFFFFFF;
      @(posedge clk);
      #1;
      in_hub = 32'h7F7FFFFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("both_full_in_ready", {63'h0, in_ready}, 64'h0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid_reset_state", {61'h0, out_valid, sticky_inexact, sticky_overflow}, 64'h0);
      out_ready = 1'b1;
      send_one("post_reset", 32'h40400001, 32'h40400002, 1'b1, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
